// File: rtl/mem_ctr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctr_pkg
//  Purpose  : Shared types and sizing helpers for the frame-buffer write path
//             (FSM state encoding, BRAM address/data widths, frame sizing).
//  Revision : 1.0 - initial release
// ============================================================================
package mem_ctr_pkg;

    // Write-controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // BRAM port A geometry; 19 bits covers a full 540x540 frame.
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    // Number of pixels in one frame.
    function automatic int frame_pixels(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wr_ctr_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with first-word-fall-through read data and
//             full/empty flags. A synchronous clear empties it in one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Pointer update; reset and clear both flush the contents.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wr_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wr_ctr
//  Purpose  : Captures one frame of pixels from a valid/ready stream into a
//             small FIFO and writes them sequentially to BRAM port A,
//             stalling on wr_gnt_i, then pulses frame_done_o.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wr_ctr
    import mem_ctr_pkg::*;
#(
    parameter int MAX_ROW    = 540,
    parameter int MAX_COL    = 540,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              pix_valid_i,
    input  logic [DATA_W-1:0] pix_data_i,
    output logic              pix_ready_o,
    input  logic              wr_gnt_i,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addra_o,
    output logic [DATA_W-1:0] d2mema_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int                FRAME_PIXELS = frame_pixels(MAX_ROW, MAX_COL);
    localparam int                CNT_W        = cnt_width(FRAME_PIXELS);
    localparam logic [CNT_W-1:0]  C_FRAME_CNT  = CNT_W'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] C_LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    acc_cnt_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                ena_q;
    logic                wea_q;
    logic [ADDR_W-1:0]   addra_q;
    logic [DATA_W-1:0]   d2mema_q;
    logic                frame_done_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_rdata;
    logic                push;
    logic                pop;
    logic                clr;

    // Ready ignores a same-cycle pop: a full FIFO always refuses the push.
    assign pix_ready_o = rst_n && (state_q == ST_WRITE) && !fifo_full &&
                         (acc_cnt_q < C_FRAME_CNT);
    assign push        = pix_valid_i && pix_ready_o;
    assign pop         = (state_q == ST_WRITE) && !fifo_empty && wr_gnt_i;
    assign clr         = (state_q == ST_IDLE) && start_i;

    assign busy_o       = (state_q != ST_IDLE);
    assign ena_o        = ena_q;
    assign wea_o        = wea_q;
    assign addra_o      = addra_q;
    assign d2mema_o     = d2mema_q;
    assign frame_done_o = frame_done_q;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .push_i  (push),
        .wdata_i (pix_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Frame FSM with registered BRAM strobes, address/data and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_cnt_q    <= '0;
            wr_addr_q    <= '0;
            ena_q        <= 1'b0;
            wea_q        <= 1'b0;
            addra_q      <= '0;
            d2mema_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            ena_q        <= 1'b0;
            wea_q        <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q   <= ST_WRITE;
                        acc_cnt_q <= '0;
                        wr_addr_q <= '0;
                    end
                end
                ST_WRITE: begin
                    if (push) begin
                        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                    end
                    if (pop) begin
                        ena_q    <= 1'b1;
                        wea_q    <= 1'b1;
                        addra_q  <= wr_addr_q;
                        d2mema_q <= fifo_rdata;
                        if (wr_addr_q == C_LAST_ADDR) begin
                            wr_addr_q <= '0;
                            state_q   <= ST_DONE;
                        end else begin
                            wr_addr_q <= wr_addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // The final write strobe is on the BRAM port now; flag
                    // completion on the following cycle.
                    frame_done_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wr_ctr
//  Purpose  : Self-checking bench for mem_wr_ctr (4x4 frame, 4-entry FIFO)
//             using a queue-based reference model of the pixel stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wr_ctr;

    localparam int R = 4;
    localparam int C = 4;
    localparam int D = 4;
    localparam int N = R * C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic [7:0]  pix_data_i = 8'h00;
    logic        wr_gnt_i = 1'b0;
    logic        pix_ready_o;
    logic        ena_o;
    logic        wea_o;
    logic [18:0] addra_o;
    logic [7:0]  d2mema_o;
    logic        busy_o;
    logic        frame_done_o;

    mem_wr_ctr #(
        .MAX_ROW    (R),
        .MAX_COL    (C),
        .FIFO_DEPTH (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .pix_valid_i  (pix_valid_i),
        .pix_data_i   (pix_data_i),
        .pix_ready_o  (pix_ready_o),
        .wr_gnt_i     (wr_gnt_i),
        .ena_o        (ena_o),
        .wea_o        (wea_o),
        .addra_o      (addra_o),
        .d2mema_o     (d2mema_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is "in progress" from start until N pixels
    // have been written; the FIFO is modelled as the queue of accepted but
    // not yet written pixels.
    bit         m_busy;
    bit         m_writing;
    int         m_acc;
    int         m_pop;
    logic [7:0] m_q[$];
    bit         e_ena;
    bit         e_fd;
    int         e_addr;
    logic [7:0] e_data;

    int n_writes;
    int n_hs;
    bit seen_fd;

    task automatic model_reset();
        m_busy    = 1'b0;
        m_writing = 1'b0;
        m_acc     = 0;
        m_pop     = 0;
        m_q.delete();
        e_ena     = 1'b0;
        e_fd      = 1'b0;
        e_addr    = 0;
        e_data    = 8'h00;
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check outputs.
    task automatic step(input bit v, input logic [7:0] d, input bit g, input bit s);
        int occ;
        bit exp_ready;
        bit do_pop;
        pix_valid_i = v;
        pix_data_i  = d;
        wr_gnt_i    = g;
        start_i     = s;
        #1;
        occ       = m_acc - m_pop;
        exp_ready = m_writing && (occ < D) && (m_acc < N);
        do_pop    = m_writing && (occ > 0) && g;
        checks++;
        if (pix_ready_o !== exp_ready) begin
            errors++;
            $display("FAIL ready t=%0t got %b expected %b", $time, pix_ready_o, exp_ready);
        end
        if (v && pix_ready_o === 1'b1) n_hs++;
        e_ena = 1'b0;
        e_fd  = 1'b0;
        if (!m_busy) begin
            if (s) begin
                m_busy    = 1'b1;
                m_writing = 1'b1;
                m_acc     = 0;
                m_pop     = 0;
                m_q.delete();
            end
        end else if (m_writing) begin
            if (do_pop) begin
                e_ena  = 1'b1;
                e_addr = m_pop;
                e_data = m_q.pop_front();
                m_pop++;
                if (m_pop == N) m_writing = 1'b0;
            end
            if (v && exp_ready) begin
                m_q.push_back(d);
                m_acc++;
            end
        end else begin
            m_busy = 1'b0;
            e_fd   = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (ena_o !== e_ena || wea_o !== e_ena) begin
            errors++;
            $display("FAIL strobe t=%0t got ena=%b wea=%b expected %b", $time, ena_o, wea_o, e_ena);
        end
        checks++;
        if (addra_o !== 19'(e_addr) || d2mema_o !== e_data) begin
            errors++;
            $display("FAIL write t=%0t got addr=%0d data=%0d expected addr=%0d data=%0d",
                     $time, addra_o, d2mema_o, e_addr, e_data);
        end
        checks++;
        if (busy_o !== m_busy || frame_done_o !== e_fd) begin
            errors++;
            $display("FAIL status t=%0t got busy=%b done=%b expected busy=%b done=%b",
                     $time, busy_o, frame_done_o, m_busy, e_fd);
        end
        if (ena_o === 1'b1) n_writes++;
        if (frame_done_o === 1'b1) seen_fd = 1'b1;
    endtask

    task automatic reset_dut(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            pix_valid_i = 1'($urandom);
            pix_data_i  = 8'($urandom);
            wr_gnt_i    = 1'($urandom);
            start_i     = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({pix_ready_o, ena_o, wea_o, addra_o, d2mema_o, busy_o, frame_done_o} !== '0) begin
                errors++;
                $display("FAIL reset_outputs t=%0t got rdy=%b ena=%b wea=%b addr=%0d data=%0d busy=%b done=%b expected all zero",
                         $time, pix_ready_o, ena_o, wea_o, addra_o, d2mema_o, busy_o, frame_done_o);
            end
        end
        rst_n = 1'b1;
        model_reset();
        start_i = 1'b0;
        pix_valid_i = 1'b0;
    endtask

    // Starts a frame and runs it to frame_done_o. pv/pg are valid/grant
    // probabilities in percent; seq selects data equal to accept index.
    task automatic run_frame(input int pv, input int pg, input bit seq, input string name);
        logic [7:0] dd;
        n_writes = 0;
        n_hs     = 0;
        seen_fd  = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 600 && !seen_fd; i++) begin
            dd = seq ? 8'(m_acc) : 8'($urandom);
            step(($urandom_range(99) < pv), dd, ($urandom_range(99) < pg), 1'b0);
        end
        checks++;
        if (!seen_fd || n_writes != N) begin
            errors++;
            $display("FAIL %s frame_end got done=%b writes=%0d expected done=1 writes=%0d",
                     name, seen_fd, n_writes, N);
        end
    endtask

    task automatic test_reset();
        reset_dut(2);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_stream();
        run_frame(100, 100, 1'b1, "stream");
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (busy_o !== 1'b0 || d2mema_o !== 8'd15 || addra_o !== 19'd15) begin
            errors++;
            $display("FAIL stream_final got busy=%b addr=%0d data=%0d expected busy=0 addr=15 data=15",
                     busy_o, addra_o, d2mema_o);
        end
    endtask

    task automatic test_backpressure();
        n_writes = 0;
        n_hs     = 0;
        seen_fd  = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        checks++;
        if (n_hs != D || n_writes != 0 || pix_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL backpressure got accepts=%0d writes=%0d ready=%b expected accepts=%0d writes=0 ready=0",
                     n_hs, n_writes, pix_ready_o, D);
        end
        for (int i = 0; i < 200 && !seen_fd; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        checks++;
        if (!seen_fd || n_writes != N) begin
            errors++;
            $display("FAIL backpressure_drain got done=%b writes=%0d expected done=1 writes=%0d",
                     seen_fd, n_writes, N);
        end
    endtask

    task automatic test_oversupply();
        int offered;
        n_writes = 0;
        n_hs     = 0;
        seen_fd  = 1'b0;
        offered  = 0;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 200 && (offered < 20 || !seen_fd); i++) begin
            step(offered < 20, 8'($urandom), 1'b1, 1'b0);
            if (pix_valid_i && (n_hs < N)) offered = n_hs;
            if (n_hs >= N) offered++;
        end
        checks++;
        if (n_hs != N || n_writes != N) begin
            errors++;
            $display("FAIL oversupply got accepts=%0d writes=%0d expected %0d", n_hs, n_writes, N);
        end
    endtask

    task automatic test_start_busy();
        bit pulsed;
        n_writes = 0;
        seen_fd  = 1'b0;
        pulsed   = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 300 && !seen_fd; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), (n_writes == 4) && !pulsed);
            if (start_i) pulsed = 1'b1;
        end
        checks++;
        if (!pulsed || !seen_fd || n_writes != N) begin
            errors++;
            $display("FAIL start_busy got pulsed=%b done=%b writes=%0d expected 1 1 %0d",
                     pulsed, seen_fd, n_writes, N);
        end
    endtask

    task automatic test_reset_mid();
        n_writes = 0;
        seen_fd  = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 200 && n_writes < 7; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        checks++;
        if (n_writes != 7 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre got writes=%0d busy=%b expected 7 1", n_writes, busy_o);
        end
        reset_dut(3);
        run_frame(70, 70, 1'b0, "reset_mid");
    endtask

    task automatic test_back_to_back();
        run_frame(100, 100, 1'b1, "b2b_first");
        run_frame(100, 100, 1'b1, "b2b_second");
        checks++;
        if (addra_o !== 19'(N - 1) || d2mema_o !== 8'(N - 1)) begin
            errors++;
            $display("FAIL b2b_last got addr=%0d data=%0d expected %0d", addra_o, d2mema_o, N - 1);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            run_frame($urandom_range(90, 30), $urandom_range(90, 30), 1'b0, "random");
            repeat ($urandom_range(2)) step(1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        test_backpressure();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        test_oversupply();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        test_start_busy();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        test_reset_mid();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        test_back_to_back();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wr_ctr.md
MEM_WR_CTR -- requirements
Module: mem_wr_ctr

Interface
REQ-001 SHALL have parameter MAX_ROW, default 540, frame rows.
REQ-002 SHALL have parameter MAX_COL, default 540, frame columns.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, input buffer entries (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port start_i, input, 1, begin capture of one frame.
REQ-007 SHALL have port pix_valid_i, input, 1, upstream pixel valid.
REQ-008 SHALL have port pix_data_i, input, 8, upstream pixel value.
REQ-009 SHALL have port pix_ready_o, output, 1, pixel accepted when valid and ready are both high.
REQ-010 SHALL have port wr_gnt_i, input, 1, BRAM port A available; low stalls writes.
REQ-011 SHALL have port ena_o, input-side BRAM, output, 1, BRAM port A enable.
REQ-012 SHALL have port wea_o, output, 1, BRAM port A write enable.
REQ-013 SHALL have port addra_o, output, 19, BRAM port A address.
REQ-014 SHALL have port d2mema_o, output, 8, BRAM port A write data.
REQ-015 SHALL have port busy_o, output, 1, high when the state is not IDLE.
REQ-016 SHALL have port frame_done_o, output, 1, one-cycle pulse at frame end.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE and DONE.
REQ-018 SHALL transition IDLE->WRITE on start_i; this clears the accept counter, write address and FIFO.
REQ-019 SHALL ignore start_i in WRITE and DONE.
REQ-020 SHALL drive pix_ready_o = (state==WRITE) && !fifo_full && (accept count < MAX_ROW*MAX_COL).
REQ-021 SHALL compute pix_ready_o independent of same-cycle pop: FIFO full blocks push even when a pop occurs.
REQ-022 SHALL, in WRITE, pop one FIFO entry per cycle when FIFO not empty and wr_gnt_i=1.
REQ-023 SHALL register each pop into ena_o=wea_o=1, addra_o=write address, d2mema_o=popped data, valid for exactly one cycle.
REQ-024 SHALL drive ena_o=wea_o=0 in cycles with no pop; addra_o and d2mema_o then hold their last values.
REQ-025 SHALL give a minimum latency of 2 cycles: a pixel accepted in cycle N raises ena_o in cycle N+2.
REQ-026 SHALL increment the write address per pop, wrapping MAX_ROW*MAX_COL-1 -> 0.
REQ-027 SHALL transition WRITE->DONE on the pop at address MAX_ROW*MAX_COL-1.
REQ-028 SHALL raise frame_done_o for the single DONE cycle, one cycle after the final ena_o pulse; DONE->IDLE unconditionally.
REQ-029 SHALL write pixels in acceptance order, never duplicating or dropping any; the 19-bit address SHALL hold 540*540-1.
REQ-030 SHALL require wr_gnt_i low only to delay writes; it SHALL NOT affect acceptance until the FIFO is full.

Reset
REQ-031 SHALL, with rst_n=0 at a clock edge, force state IDLE, flush the FIFO, zero both counters, and zero pix_ready_o, ena_o, wea_o, addra_o, d2mema_o, busy_o and frame_done_o, including mid-frame.

Structure
REQ-032 SHALL place the state enum and the FRAME_PIXELS=MAX_ROW*MAX_COL width helpers in a shared package, mem_ctr_pkg.
REQ-033 SHALL instantiate a single sub-module, sync_fifo, parameterised by width 8 and FIFO_DEPTH, with full and empty flags.

Verification (MAX_ROW=4, MAX_COL=4, FIFO_DEPTH=4)
REQ-034 SHALL test a continuous stream. Stimulus: start, valid always high, data 0..15, wr_gnt_i=1. Response: 16 writes at addresses 0..15 with data equal to address; frame_done_o one cycle after the last write; busy_o low afterwards.
REQ-035 SHALL test backpressure. Stimulus: hold wr_gnt_i=0 for 10 cycles after start with valid high. Response: pix_ready_o drops after 4 accepts; no ena_o; after wr_gnt_i rises, all 16 pixels are written in order.
REQ-036 SHALL test over-supply. Stimulus: offer 20 pixels. Response: exactly 16 accepted; pix_ready_o=0 after the 16th accept.
REQ-037 SHALL test start while busy. Stimulus: pulse start_i at the 5th write. Response: no address reset; frame completes normally.
REQ-038 SHALL test reset mid-frame. Stimulus: rst_n=0 after 7 writes, then a new start. Response: all outputs zero during reset; the new frame writes from address 0 with a flushed FIFO.
REQ-039 SHALL test back-to-back frames. Stimulus: start_i the cycle after frame_done_o. Response: second frame writes 0..15; no missed start.
